// File: rtl/k005297_dldncntr.sv
// k005297_dldncntr: serial LSB-first data-length down-counter, shifted once per tick across rotation slots 1..WIDTH.
// Optional build macro K005297_DLDNCNTR_WRAP_EN: DONE accepts decrements, 0 wraps to all-ones and pulses o_DLCNTR_BFLAG.
module k005297_dldncntr #(
   parameter int WIDTH = 10
) (
   input  logic        i_MCLK,
   input  logic        i_RST,
   input  logic        i_CLK2M_PCEN_n,
   input  logic [19:0] i_ROT20_n,
   input  logic        i_DLLOAD_START_n,
   input  logic        i_DLLOAD_DATA,
   input  logic        i_DLCNT_EN,
   output logic        o_DLCNTR_LSB,
   output logic        o_DLCNTR_ZERO,
   output logic        o_DLCNTR_DONE,
   output logic        o_DLCNTR_BFLAG,
   output logic        o_DLCNTR_BUSY
);
`ifdef K005297_DLDNCNTR_WRAP_EN
   localparam logic L_WRAP = 1'b1;
`else
   localparam logic L_WRAP = 1'b0;
`endif
   localparam int PW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [PW-1:0]    r_pos;
   logic             r_win, r_ldreq, r_pend, r_borrow, r_zacc;
   logic             r_zero, r_done, r_bflag, r_busy;
   logic             w_tick, w_start, w_rot0, w_shift, w_pos0, w_last, w_hold, w_subst;
   logic             w_sub, w_bin, w_newbit, w_bout, w_zacc_nxt, w_busy_nxt;
   logic             w_unused_rot;

   assign w_unused_rot = &i_ROT20_n[19:1];

   // A pending start (w_hold) turns the rest of the current window into a plain recirculate.
   always_comb begin : datapath
      w_tick     = ~i_CLK2M_PCEN_n;
      w_start    = w_tick & ~i_DLLOAD_START_n;
      w_rot0     = w_tick & ~i_ROT20_n[0];
      w_shift    = w_tick & r_win;
      w_pos0     = (r_pos == '0);
      w_last     = w_shift & (r_pos == PW'(WIDTH - 1));
      w_hold     = r_ldreq | w_start;
      w_subst    = ~w_hold & ((r_state == S_COUNT) | (L_WRAP & (r_state == S_DONE)));
      w_sub      = w_shift & w_pos0 & w_subst & r_pend;
      w_bin      = w_pos0 ? 1'b0 : r_borrow;
      w_bout     = (~r_cnt[0] & (w_sub | w_bin)) | (r_cnt[0] & w_sub & w_bin);
      w_newbit   = r_cnt[0];
      if (w_subst)
         w_newbit = r_cnt[0] ^ w_sub ^ w_bin;
      else if (!w_hold && r_state == S_LOAD)
         w_newbit = i_DLLOAD_DATA;
      w_zacc_nxt = w_pos0 ? w_newbit : (r_zacc | w_newbit);
   end

   always_ff @(posedge i_MCLK) begin : state_reg
      if (i_RST)
         r_state <= S_IDLE;
      else if (w_tick)
         r_state <= w_state_nxt;
   end

   always_comb begin : next_state
      w_state_nxt = r_state;
      if (w_rot0 && w_hold)
         w_state_nxt = S_LOAD;
      else if (w_last && !w_hold && (r_state == S_LOAD || w_subst))
         w_state_nxt = w_zacc_nxt ? S_COUNT : S_DONE;
   end

   always_comb begin : state_out
      w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_COUNT);
   end

   always_ff @(posedge i_MCLK) begin : regs
      if (i_RST) begin
         r_cnt    <= '0;
         r_pos    <= '0;
         r_win    <= 1'b0;
         r_ldreq  <= 1'b0;
         r_pend   <= 1'b0;
         r_borrow <= 1'b0;
         r_zacc   <= 1'b0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
         r_bflag  <= 1'b0;
         r_busy   <= 1'b0;
      end else if (w_tick) begin
         r_busy  <= w_busy_nxt;
         r_bflag <= 1'b0;
         if (w_rot0) begin
            r_win <= 1'b1;
            r_pos <= '0;
         end else if (w_shift) begin
            r_cnt    <= {w_newbit, r_cnt[WIDTH-1:1]};
            r_pos    <= r_pos + PW'(1);
            r_borrow <= w_bout;
            r_zacc   <= w_zacc_nxt;
            if (w_last) begin
               r_win   <= 1'b0;
               r_zero  <= ~w_zacc_nxt;
               r_bflag <= L_WRAP & w_subst & w_bout;
               if (!w_hold)
                  r_done <= (w_state_nxt == S_DONE);
            end
         end
         // Start arriving on the window-start tick loads immediately; otherwise it waits for the next one.
         if (w_rot0)
            r_ldreq <= 1'b0;
         else if (w_start)
            r_ldreq <= 1'b1;
         if (w_start)
            r_done <= 1'b0;
         if (w_start || (r_state == S_DONE && !L_WRAP))
            r_pend <= 1'b0;
         else if (i_DLCNT_EN)
            r_pend <= 1'b1;
         else if (w_sub)
            r_pend <= 1'b0;
      end
   end

   assign o_DLCNTR_LSB   = r_cnt[0];
   assign o_DLCNTR_ZERO  = r_zero;
   assign o_DLCNTR_DONE  = r_done;
   assign o_DLCNTR_BFLAG = r_bflag;
   assign o_DLCNTR_BUSY  = r_busy;

endmodule

// File: tb/tb_k005297_dldncntr.sv
// Scoreboard bench for k005297_dldncntr: directed rotations; the counter is read back serially from o_DLCNTR_LSB.
`timescale 1ns/1ps
module tb_k005297_dldncntr;
   localparam int W = 10;

   logic        i_MCLK = 1'b0;
   logic        i_RST;
   logic        i_CLK2M_PCEN_n;
   logic [19:0] i_ROT20_n;
   logic        i_DLLOAD_START_n;
   logic        i_DLLOAD_DATA;
   logic        i_DLCNT_EN;
   logic        o_DLCNTR_LSB, o_DLCNTR_ZERO, o_DLCNTR_DONE, o_DLCNTR_BFLAG, o_DLCNTR_BUSY;

   k005297_dldncntr #(.WIDTH(W)) dut (
      .i_MCLK(i_MCLK), .i_RST(i_RST), .i_CLK2M_PCEN_n(i_CLK2M_PCEN_n), .i_ROT20_n(i_ROT20_n),
      .i_DLLOAD_START_n(i_DLLOAD_START_n), .i_DLLOAD_DATA(i_DLLOAD_DATA), .i_DLCNT_EN(i_DLCNT_EN),
      .o_DLCNTR_LSB(o_DLCNTR_LSB), .o_DLCNTR_ZERO(o_DLCNTR_ZERO), .o_DLCNTR_DONE(o_DLCNTR_DONE),
      .o_DLCNTR_BFLAG(o_DLCNTR_BFLAG), .o_DLCNTR_BUSY(o_DLCNTR_BUSY)
   );

   always #5 i_MCLK = ~i_MCLK;

   // cnt/zero/done/busy: state seen at slot 1 of rotation `rot`; bflag: pulse at the end of that window
   typedef struct {
      int           rot;
      logic [W-1:0] cnt;
      logic         zero, done, busy, bflag;
   } exp_t;

   exp_t         q[$];
   int           n_cmp = 0, n_bad = 0;
   int           slot = 0, rot_idx = 0;
   logic [W-1:0] ld_val = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic logic [19:0] m(input int s);
      m = 20'd1 << s;
   endfunction

   task automatic advance();
      if (slot == 19) begin
         slot = 0;
         rot_idx++;
      end else
         slot++;
   endtask

   task automatic do_tick(input bit st, input bit en);
      i_ROT20_n        = ~(20'd1 << slot);
      i_CLK2M_PCEN_n   = 1'b0;
      i_DLLOAD_START_n = ~st;
      i_DLCNT_EN       = en;
      i_DLLOAD_DATA    = (slot >= 1 && slot <= W) ? ld_val[slot-1] : 1'b0;
      @(posedge i_MCLK);
      @(negedge i_MCLK);
      i_CLK2M_PCEN_n   = 1'b1;
      i_DLLOAD_START_n = 1'b1;
      i_DLCNT_EN       = 1'b0;
      @(negedge i_MCLK);
      advance();
   endtask

   task automatic rst_edge();
      check("prerst_busy", W'(o_DLCNTR_BUSY), W'(1));
      i_CLK2M_PCEN_n = 1'b1;
      i_RST          = 1'b1;
      @(posedge i_MCLK);
      #1;
      check("midrst_zero", W'(o_DLCNTR_ZERO), W'(1));
      check("midrst_done", W'(o_DLCNTR_DONE), W'(0));
      check("midrst_busy", W'(o_DLCNTR_BUSY), W'(0));
      check("midrst_bflag", W'(o_DLCNTR_BFLAG), W'(0));
      check("midrst_lsb", W'(o_DLCNTR_LSB), W'(0));
      @(negedge i_MCLK);
      i_RST = 1'b0;
      @(negedge i_MCLK);
      advance();
   endtask

   task automatic run_rot(input int st, input logic [19:0] en, input int rs);
      for (int k = 0; k < 20; k++) begin
         if (slot == rs) rst_edge();
         else do_tick(slot == st, en[slot]);
      end
   endtask

   task automatic step(input logic [W-1:0] c, input logic z, input logic d, input logic b,
                       input logic bf, input int st, input logic [19:0] en);
      exp_t e;
      e.rot = rot_idx; e.cnt = c; e.zero = z; e.done = d; e.busy = b; e.bflag = bf;
      q.push_back(e);
      run_rot(st, en, -1);
   endtask

   // Monitor: rebuilds the counter from the serial tap during each window and compares at slot W+1.
   logic [W-1:0] cap;
   logic         s_zero, s_done, s_busy;
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_MCLK);
         #2;
         if (!i_RST && !i_CLK2M_PCEN_n) begin
            if (slot == 1) begin
               s_zero = o_DLCNTR_ZERO; s_done = o_DLCNTR_DONE; s_busy = o_DLCNTR_BUSY;
               cap = '0;
            end
            if (slot >= 1 && slot <= W) cap[slot-1] = o_DLCNTR_LSB;
            if (slot == W + 1 && q.size() > 0 && q[0].rot == rot_idx) begin
               e = q.pop_front();
               check($sformatf("r%0d_cnt", rot_idx), cap, e.cnt);
               check($sformatf("r%0d_zero", rot_idx), W'(s_zero), W'(e.zero));
               check($sformatf("r%0d_done", rot_idx), W'(s_done), W'(e.done));
               check($sformatf("r%0d_busy", rot_idx), W'(s_busy), W'(e.busy));
               check($sformatf("r%0d_bflag", rot_idx), W'(o_DLCNTR_BFLAG), W'(e.bflag));
            end
         end
      end
   end

   initial begin : main
      logic [19:0] x13, x14;
`ifdef K005297_DLDNCNTR_WRAP_EN
      x13 = '0;
      x14 = '0;
`else
      x13 = m(13) | m(15);
      x14 = m(3) | m(15);
`endif
      i_RST = 1'b1; i_CLK2M_PCEN_n = 1'b1; i_ROT20_n = '1;
      i_DLLOAD_START_n = 1'b1; i_DLLOAD_DATA = 1'b0; i_DLCNT_EN = 1'b0;
      repeat (3) @(negedge i_MCLK);
      i_RST = 1'b0;
      check("rst_zero", W'(o_DLCNTR_ZERO), W'(1));
      check("rst_done", W'(o_DLCNTR_DONE), W'(0));
      check("rst_busy", W'(o_DLCNTR_BUSY), W'(0));
      check("rst_bflag", W'(o_DLCNTR_BFLAG), W'(0));
      check("rst_lsb", W'(o_DLCNTR_LSB), W'(0));

      for (int r = 0; r < 3; r++) step(0, 1, 0, 0, 0, -1, '0);  // idle rotations 0..2
      ld_val = 10'd5;
      step(0, 1, 0, 0, 0, 5, '0);          // start mid-window, load waits
      step(0, 1, 0, 1, 0, -1, '0);         // load 5
      step(5, 0, 0, 1, 0, -1, m(15));
      step(5, 0, 0, 1, 0, -1, m(15));
      step(4, 0, 0, 1, 0, -1, m(15));
      step(3, 0, 0, 1, 0, -1, m(15));
      step(2, 0, 0, 1, 0, -1, m(15));
      step(1, 0, 0, 1, 0, -1, '0);
      ld_val = 10'd1;
      step(0, 1, 1, 0, 0, 15, '0);         // rot 11: DONE, then start
      step(0, 1, 0, 1, 0, -1, m(13) | m(15) | m(17));
      step(1, 0, 0, 1, 0, -1, x13);
      step(0, 1, 1, 0, 0, -1, x14);
      ld_val = 10'd0;
      step(0, 1, 1, 0, 0, 15, '0);         // rot 15
      step(0, 1, 0, 1, 0, -1, '0);         // load 0
      step(0, 1, 1, 0, 0, -1, m(15));      // DONE right after the load
`ifdef K005297_DLDNCNTR_WRAP_EN
      step(0, 1, 1, 0, 1, -1, '0);         // wrap window, BFLAG pulse
      ld_val = 10'd700;
      step(1023, 0, 0, 1, 0, 15, '0);
`else
      step(0, 1, 1, 0, 0, -1, '0);
      ld_val = 10'd700;
      step(0, 1, 1, 0, 0, 15, '0);
`endif
      run_rot(-1, m(15), -1);              // rot 20: load 700
      step(700, 0, 0, 1, 0, -1, m(15));
      step(699, 0, 0, 1, 0, -1, '0);
      ld_val = 10'd3;
      step(698, 0, 0, 1, 0, 4, m(4));      // start + decrement together mid-window
      step(698, 0, 0, 1, 0, -1, '0);
      step(3, 0, 0, 1, 0, -1, '0);
      step(3, 0, 0, 1, 0, -1, '0);
      run_rot(-1, '0, 5);                  // rot 27: reset mid-COUNT
      step(0, 1, 0, 0, 0, -1, '0);
      step(0, 1, 0, 0, 0, -1, '0);

      check("queue_drained", W'(q.size()), W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
